// File: rtl/gpio_regbank.sv
// gpio_regbank: maps a 32-bit GPIO host word onto 2**ADDR_BITS configuration
// registers with edge-triggered writes, optional shadow/commit, and readback.
module gpio_regbank #(
    parameter int unsigned ADDRESS_PREFIX = 0,
    parameter int unsigned PREFIX_BITS    = 2,
    parameter int unsigned ADDR_BITS      = 3,
    parameter int unsigned SHADOW_MODE    = 0,
    parameter logic [(2**ADDR_BITS)*(31-PREFIX_BITS-ADDR_BITS)-1:0] RESET_VALUES = '0
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_ni,
    input  logic [31:0]                                            gpio1_i,
    output logic [31:0]                                            gpio2_o,
    output logic [(2**ADDR_BITS)*(31-PREFIX_BITS-ADDR_BITS)-1:0]   data_o,
    output logic [(2**ADDR_BITS)-1:0]                              update_o,
    output logic                                                   pending_o
);

    localparam int unsigned N_REGS = 2 ** ADDR_BITS;
    localparam int unsigned DW     = 31 - PREFIX_BITS - ADDR_BITS;
    localparam int unsigned CTRL   = N_REGS - 1;

    logic [31:0]                  gpio1_q;
    logic                         we_prev_q;
    logic                         sampled_q;
    logic                         armed_q;
    logic [N_REGS-1:0][DW-1:0]    active_q;
    logic [N_REGS-1:0][DW-1:0]    shadow_q;

    logic                         we_q;
    logic [PREFIX_BITS-1:0]       prefix_q;
    logic [ADDR_BITS-1:0]         addr_q;
    logic [DW-1:0]                data_q;

    logic                         wr_fire;
    logic                         armed_d;
    logic                         ack_d;
    logic [N_REGS-1:0][DW-1:0]    active_d;
    logic [N_REGS-1:0][DW-1:0]    shadow_d;
    logic                         pending_d;
    logic [N_REGS-1:0]            update_d;
    logic [DW-1:0]                rdata_d;

    // Field split of the registered host word.
    assign we_q     = gpio1_q[31];
    assign prefix_q = gpio1_q[30 -: PREFIX_BITS];
    assign addr_q   = gpio1_q[DW +: ADDR_BITS];
    assign data_q   = gpio1_q[DW-1:0];

    // Arming only counts a we=0 that was actually sampled from the host, not
    // the reset-zero of gpio1_q, so a we held across reset release never writes.
    assign armed_d = armed_q | (sampled_q & ~we_q);
    assign wr_fire = we_q & ~we_prev_q & armed_q & (prefix_q == PREFIX_BITS'(ADDRESS_PREFIX));
    assign ack_d   = we_q & armed_q;

    // Next-state of register file, shadow copy, pending flag and update strobes.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_o;
        update_d  = '0;
        if (wr_fire) begin
            if (SHADOW_MODE == 0) begin
                active_d[addr_q] = data_q;
                update_d[addr_q] = 1'b1;
            end else if (addr_q != ADDR_BITS'(CTRL)) begin
                shadow_d[addr_q] = data_q;
                pending_d        = 1'b1;
            end else if (data_q[0]) begin
                for (int unsigned k = 0; k < CTRL; k++) begin
                    update_d[k] = (active_q[k] != shadow_q[k]);
                    active_d[k] = shadow_q[k];
                end
                pending_d = 1'b0;
            end
        end
    end

    // Readback uses post-update values so the word carrying ack=1 already
    // reflects the write that ack acknowledges.
    always_comb begin
        rdata_d = '0;
        if (SHADOW_MODE == 0) begin
            rdata_d = active_d[addr_q];
        end else if (addr_q == ADDR_BITS'(CTRL)) begin
            rdata_d = DW'(pending_d);
        end else begin
            rdata_d = shadow_d[addr_q];
        end
    end

    // Active register contents; the control slot has no active copy in shadow mode.
    always_comb begin
        data_o = active_q;
        if (SHADOW_MODE != 0) begin
            data_o[CTRL*DW +: DW] = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio1_q   <= '0;
            we_prev_q <= 1'b0;
            sampled_q <= 1'b0;
            armed_q   <= 1'b0;
            active_q  <= RESET_VALUES;
            shadow_q  <= RESET_VALUES;
            gpio2_o   <= '0;
            update_o  <= '0;
            pending_o <= 1'b0;
        end else begin
            gpio1_q   <= gpio1_i;
            we_prev_q <= we_q;
            sampled_q <= 1'b1;
            armed_q   <= armed_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            gpio2_o   <= {ack_d, PREFIX_BITS'(ADDRESS_PREFIX), addr_q, rdata_d};
            update_o  <= update_d;
            pending_o <= pending_d;
        end
    end

endmodule

// File: tb/tb_gpio_regbank.sv
// Scoreboard bench for gpio_regbank: one direct-mode and one shadow-mode instance.
module tb_gpio_regbank;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 26;
    localparam int unsigned VW = N * DW;
    localparam logic [VW-1:0] RV_D = {26'h107, 26'h106, 26'h105, 26'h104,
                                      26'h103, 26'h102, 26'h101, 26'h100};

    typedef struct packed {
        logic [N-1:0]  upd;
        logic [VW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   g1_d, g1_s, g2_d, g2_s;
    logic [VW-1:0] dat_d, dat_s;
    logic [N-1:0]  upd_d, upd_s;
    logic          pend_d, pend_s;

    int            tests = 0;
    int            fails = 0;
    exp_t          q_d[$];
    exp_t          q_s[$];
    exp_t          e_d, e_s;
    logic [VW-1:0] mdl_d, mdl_s;

    always #5 clk = ~clk;

    gpio_regbank #(
        .ADDRESS_PREFIX(0), .PREFIX_BITS(2), .ADDR_BITS(3), .SHADOW_MODE(0), .RESET_VALUES(RV_D)
    ) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .gpio1_i(g1_d), .gpio2_o(g2_d),
        .data_o(dat_d), .update_o(upd_d), .pending_o(pend_d)
    );

    gpio_regbank #(
        .ADDRESS_PREFIX(0), .PREFIX_BITS(2), .ADDR_BITS(3), .SHADOW_MODE(1), .RESET_VALUES('0)
    ) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .gpio1_i(g1_s), .gpio2_o(g2_s),
        .data_o(dat_s), .update_o(upd_s), .pending_o(pend_s)
    );

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for gpio2[31] (ack) to reach val on the selected instance.
    task automatic wait_ack(input int sel, input logic val, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (((sel == 0) ? g2_d[31] : g2_s[31]) === val) seen = 1'b1;
        end
        check(name, VW'(seen), VW'(1'b1));
    endtask

    // Full host handshake on the direct instance with an expected write.
    task automatic write_d(input logic [2:0] a, input logic [25:0] d);
        logic [N-1:0] m;
        m = '0;
        m[a] = 1'b1;
        mdl_d[a*DW +: DW] = d;
        q_d.push_back({m, mdl_d});
        g1_d = {1'b1, 2'b00, a, d};
        wait_ack(0, 1'b1, "dir_ack_rise");
        check("dir_readback", VW'(g2_d), VW'({1'b1, 2'b00, a, d}));
        g1_d[31] = 1'b0;
        wait_ack(0, 1'b0, "dir_ack_fall");
    endtask

    // Full host handshake on the shadow instance; mask!=0 means a commit is expected.
    task automatic write_s(input logic [2:0] a, input logic [25:0] d, input logic [N-1:0] mask,
                           input logic [31:0] exp_g2, input logic exp_pend);
        if (mask != '0) q_s.push_back({mask, mdl_s});
        g1_s = {1'b1, 2'b00, a, d};
        wait_ack(1, 1'b1, "shd_ack_rise");
        check("shd_readback", VW'(g2_s), VW'(exp_g2));
        check("shd_pending", VW'(pend_s), VW'(exp_pend));
        g1_s[31] = 1'b0;
        wait_ack(1, 1'b0, "shd_ack_fall");
    endtask

    // Monitors: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && upd_d !== '0) begin
            if (q_d.size() == 0) begin
                check("dir_spurious_update", VW'(upd_d), '0);
            end else begin
                e_d = q_d.pop_front();
                check("dir_update", VW'(upd_d), VW'(e_d.upd));
                check("dir_data", dat_d, e_d.data);
            end
        end
        if (rst_n === 1'b1 && upd_s !== '0) begin
            if (q_s.size() == 0) begin
                check("shd_spurious_update", VW'(upd_s), '0);
            end else begin
                e_s = q_s.pop_front();
                check("shd_update", VW'(upd_s), VW'(e_s.upd));
                check("shd_data", dat_s, e_s.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        g1_d  = '0;
        g1_s  = '0;
        mdl_d = RV_D;
        mdl_s = '0;
        repeat (3) tick();
        check("rst_gpio2_d", VW'(g2_d), '0);
        check("rst_update_d", VW'(upd_d), '0);
        check("rst_data_d", dat_d, RV_D);
        check("rst_data_s", dat_s, '0);
        check("rst_pending_s", VW'(pend_s), '0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic write to reg3
        mdl_d[3*DW +: DW] = 26'h123;
        q_d.push_back({8'h08, mdl_d});
        g1_d = 32'h8C00_0123;
        wait_ack(0, 1'b1, "t1_ack");
        check("t1_gpio2", VW'(g2_d), VW'(32'h8C00_0123));
        check("t1_reg3", VW'(dat_d[3*DW +: DW]), VW'(26'h123));

        // we held high with new data: no second write
        g1_d = 32'h8C00_0456;
        repeat (3) tick();
        check("t2_hold_data", dat_d, mdl_d);
        check("t2_hold_gpio2", VW'(g2_d), VW'(32'h8C00_0123));
        g1_d[31] = 1'b0;
        wait_ack(0, 1'b0, "t2_ack_fall");
        write_d(3'd3, 26'h456);
        check("t2_reg3", VW'(dat_d[3*DW +: DW]), VW'(26'h456));

        // Prefix mismatch, then prefix fixed while we stays high
        g1_d = 32'hA800_0055;
        wait_ack(0, 1'b1, "t3_ack");
        check("t3_gpio2", VW'(g2_d), VW'(32'h8800_0102));
        g1_d = 32'h8800_0055;
        repeat (3) tick();
        check("t3_data", dat_d, mdl_d);
        g1_d = 32'h0800_0055;
        wait_ack(0, 1'b0, "t3_ack_fall");

        // Shadow staging, control no-op, commit, empty commit
        write_s(3'd0, 26'h5, '0, 32'h8000_0005, 1'b1);
        check("t4_data_staged0", dat_s, mdl_s);
        write_s(3'd7, 26'h0, '0, 32'h9C00_0001, 1'b1);
        write_s(3'd1, 26'h7, '0, 32'h8400_0007, 1'b1);
        check("t4_data_staged1", dat_s, mdl_s);
        mdl_s[0*DW +: DW] = 26'h5;
        mdl_s[1*DW +: DW] = 26'h7;
        write_s(3'd7, 26'h1, 8'h03, 32'h9C00_0000, 1'b0);
        check("t4_data_commit", dat_s, mdl_s);
        write_s(3'd7, 26'h1, '0, 32'h9C00_0000, 1'b0);

        // Reset with we held high
        g1_d = 32'h8400_0099;
        tick();
        rst_n = 1'b0;
        mdl_d = RV_D;
        mdl_s = '0;
        repeat (2) tick();
        check("t5_rst_data_d", dat_d, RV_D);
        check("t5_rst_data_s", dat_s, '0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("t5_no_write", dat_d, RV_D);
        check("t5_gpio2", VW'(g2_d), VW'(32'h0400_0101));
        g1_d = 32'h0400_0099;
        repeat (2) tick();
        write_d(3'd1, 26'h99);

        // Reset lands on the cycle the write would fire
        mdl_d = RV_D;
        g1_d = 32'h9000_0042;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_gpio2", VW'(g2_d), '0);
        check("t6_update", VW'(upd_d), '0);
        check("t6_data", dat_d, RV_D);
        check("t6_pending_s", VW'(pend_s), '0);
        g1_d = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("t6_lost", dat_d, RV_D);
        check("t6_gpio2_after", VW'(g2_d), VW'(32'h0000_0100));

        repeat (2) tick();
        check("dir_queue_empty", VW'(q_d.size()), '0);
        check("shd_queue_empty", VW'(q_s.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
